// File: rtl/fsk_zc_symbol_detector_pkg.sv
// Shared FSK definitions: polarity states, alphabet-width helper and default tone-plan
// constants. The modulator uses the same constants so both ends agree on the tone spacing.
package fsk_zc_symbol_detector_pkg;

    typedef enum logic [1:0] {
        POL_UNK = 2'd0,
        POL_POS = 2'd1,
        POL_NEG = 2'd2
    } pol_e;

    localparam int DEF_SPS          = 1024;
    localparam int DEF_ZC_BASE      = 8;
    localparam int DEF_ZC_STEP_LOG2 = 2;

    // Number of index bits needed for an M-ary alphabet (M a power of two).
    function automatic int log2_m(input int m);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < m) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fsk_zc_symbol_detector_zc_hysteresis.sv
// Hysteresis polarity tracker: follows the sign of the sample stream only once it clears
// +/-HYST, and flags a crossing whenever the qualified polarity flips POS<->NEG.
module zc_hysteresis
    import fsk_zc_symbol_detector_pkg::*;
#(
    parameter int HYST = 6000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_i,
    output logic        zc_pulse
);

    localparam logic signed [16:0] HYST_POS = 17'(HYST);
    localparam logic signed [16:0] HYST_NEG = 17'(-HYST);

    pol_e               pol_q;
    pol_e               pol_d;
    logic signed [16:0] sample_ext;

    assign sample_ext = 17'($signed(sample_i));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pol_d = pol_q;
        if (sample_valid) begin
            if (sample_ext >= HYST_POS) begin
                pol_d = POL_POS;
            end else if (sample_ext <= HYST_NEG) begin
                pol_d = POL_NEG;
            end
        end
    end

    // Crossing is flagged in the same cycle as the sample that causes it, so the symbol
    // counter can include it even on the last sample of a symbol.
    assign zc_pulse = ((pol_q == POL_POS) && (pol_d == POL_NEG)) ||
                      ((pol_q == POL_NEG) && (pol_d == POL_POS));

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pol_q <= POL_UNK;
        end else begin
            pol_q <= pol_d;
        end
    end

endmodule

// File: rtl/fsk_zc_symbol_detector.sv
// Non-coherent FSK detector: counts hysteresis-qualified zero crossings per symbol period
// and maps the count to a tone index, emitting one decision per symbol.
module fsk_zc_symbol_detector
    import fsk_zc_symbol_detector_pkg::*;
#(
    parameter int SPS          = DEF_SPS,
    parameter int M            = 16,
    parameter int HYST         = 6000,
    parameter int ZC_BASE      = DEF_ZC_BASE,
    parameter int ZC_STEP_LOG2 = DEF_ZC_STEP_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_i,
    input  logic        sym_start,
    output logic [3:0]  sym_out,
    output logic        sym_valid,
    output logic [15:0] zc_count,
    output logic        zc_sat
);

    localparam int             CNT_W     = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SPS - 1);
    localparam int             SYM_W     = log2_m(M);
    localparam int             MAX_IDX   = (1 << SYM_W) - 1;
    localparam int             HALF_STEP = (ZC_STEP_LOG2 > 0) ? (1 << (ZC_STEP_LOG2 - 1)) : 0;

    logic             zc_pulse;
    logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [15:0]      zc_cnt_q, zc_cnt_d;
    logic [15:0]      zc_next;
    logic             sat_hit;
    logic [3:0]       sym_out_q, sym_out_d;
    logic             sym_valid_q, sym_valid_d;
    logic [15:0]      zc_count_q, zc_count_d;
    logic             zc_sat_q, zc_sat_d;

    zc_hysteresis #(
        .HYST(HYST)
    ) u_hyst (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_i    (sample_i),
        .zc_pulse    (zc_pulse)
    );

    // Round-to-nearest tone: centre the count on tone 0, add half a step, then divide.
    function automatic logic [3:0] decide(input logic [15:0] cnt);
        logic signed [17:0] d;
        logic [17:0]        idx;
        d   = $signed({2'b00, cnt}) - $signed(18'(ZC_BASE)) + $signed(18'(HALF_STEP));
        idx = unsigned'(d) >> ZC_STEP_LOG2;
        if (d < 0) begin
            return 4'd0;
        end else if (idx > 18'(MAX_IDX)) begin
            return 4'(MAX_IDX);
        end
        return idx[3:0];
    endfunction

    assign zc_next = zc_cnt_q + {15'd0, (zc_pulse && (zc_cnt_q != 16'hFFFF))};
    assign sat_hit = zc_pulse && (zc_cnt_q >= 16'hFFFE);

    always_comb begin
        samp_cnt_d  = samp_cnt_q;
        zc_cnt_d    = zc_cnt_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        zc_count_d  = zc_count_q;
        zc_sat_d    = zc_sat_q;

        if (sym_start) begin
            // Realignment discards the partial symbol; a coincident sample opens the new one.
            if (sample_valid) begin
                samp_cnt_d = CNT_W'(1);
                zc_cnt_d   = {15'd0, zc_pulse};
            end else begin
                samp_cnt_d = '0;
                zc_cnt_d   = '0;
            end
        end else if (sample_valid) begin
            zc_sat_d = zc_sat_q | sat_hit;
            if (samp_cnt_q == LAST_SMP) begin
                zc_count_d  = zc_next;
                sym_out_d   = decide(zc_next);
                sym_valid_d = 1'b1;
                samp_cnt_d  = '0;
                zc_cnt_d    = '0;
            end else begin
                samp_cnt_d = samp_cnt_q + CNT_W'(1);
                zc_cnt_d   = zc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_q  <= '0;
            zc_cnt_q    <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            zc_count_q  <= '0;
            zc_sat_q    <= 1'b0;
        end else begin
            samp_cnt_q  <= samp_cnt_d;
            zc_cnt_q    <= zc_cnt_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            zc_count_q  <= zc_count_d;
            zc_sat_q    <= zc_sat_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign zc_count  = zc_count_q;
    assign zc_sat    = zc_sat_q;

endmodule

// File: doc/fsk_zc_symbol_detector.md
# fsk_zc_symbol_detector

Non-coherent FSK symbol detector sitting directly downstream of the channel-effects stage. Consumes the noisy 16-bit in-phase sample stream. Counts hysteresis-qualified zero crossings over each symbol period, then maps the crossing count to one of M tone indices (M = 2/4/8/16). Emits one decided symbol per symbol period to the bit-unpacking stage.

## Interface
- `SPS`, 1024: samples per symbol, ≥ 2
- `M`, 16: alphabet size; legal values 2, 4, 8, 16
- `HYST`, 6000: hysteresis threshold magnitude; must exceed peak channel noise (5000)
- `ZC_BASE`, 8: nominal crossings per symbol for tone 0
- `ZC_STEP_LOG2`, 2: log2 of crossing-count spacing between adjacent tones

Ports:
- `clk`, in, 1: the block's single clock; all logic on rising edge
- `rst`, in, 1: reset; synchronous and active-high
- `sample_valid`, in, 1: `sample_i` valid this cycle
- `sample_i`, in, 16: channel sample, two's complement
- `sym_start`, in, 1: symbol-boundary realignment strobe
- `sym_out`, out, 4: decided tone index; only the low log2(M) bits are meaningful, upper bits 0
- `sym_valid`, out, 1: one-cycle pulse qualifying `sym_out`
- `zc_count`, out, 16: crossing count of the last completed symbol (debug)
- `zc_sat`, out, 1: sticky flag, set if any symbol's count saturated; cleared only by `rst`

## Operation
- Polarity FSM states:
  - UNK is the reset state.
  - Any state to POS when `sample_i` ≥ +HYST.
  - Any state to NEG when `sample_i` ≤ −HYST.
  - Otherwise the state holds.
- Only sample-valid cycles are evaluated.
- Crossing = POS→NEG or NEG→POS transition. UNK→POS and UNK→NEG do not count.
- Polarity state persists across symbol boundaries. Only `rst` returns it to UNK.
- Sample counter runs 0..SPS−1 and advances on each accepted sample.
- Crossing counter is 16 bit and saturates at 0xFFFF. Saturation sets `zc_sat`.
- On the accepted sample with counter = SPS−1:
  - The final count, including a crossing caused by this sample, is latched into `zc_count`.
  - The decision is computed.
  - Both counters clear.
- Decision:
  - d = count − ZC_BASE + 2^(ZC_STEP_LOG2−1), computed as signed, 18 bit.
  - d < 0 → 0.
  - Otherwise idx = d >> ZC_STEP_LOG2, clamped to M−1.
- `sym_start` with `sample_valid`: that sample becomes sample 0 of a new symbol. It is evaluated normally, and its crossing counts toward the new symbol.
- `sym_start` without `sample_valid`: counters clear, and the next accepted sample is sample 0.
- In both `sym_start` cases the partial symbol is discarded and no `sym_valid` is produced.
- `sym_start` coinciding with the SPS−1 sample: `sym_start` wins. No symbol is emitted, and the sample becomes sample 0.

## Timing
- Reset values:
  - `sym_out` = 0, `sym_valid` = 0, `zc_count` = 0, `zc_sat` = 0.
  - FSM = UNK, both counters = 0.
- `rst` asserted mid-symbol discards all state. No `sym_valid` in the cycle following reset.
- Latency: `sym_valid` = 1 in the cycle after the edge that accepts sample SPS−1.
- `sym_out` and `zc_count` are registered. They hold until the next decision.
- `sym_valid` is never asserted on consecutive cycles unless SPS samples arrive; minimum spacing is SPS cycles.
- No backpressure. The downstream stage must accept every `sym_valid` pulse.
- Gaps in `sample_valid` freeze all state.

## Structure
- Shared FSK package holds:
  - Polarity state typedef (UNK/POS/NEG).
  - The `log2(M)` helper function.
  - Default SPS/ZC_BASE/ZC_STEP_LOG2 constants, shared with the modulator so tone plans stay consistent.
- Sub-module `zc_hysteresis`: polarity FSM plus a one-cycle crossing pulse.
- Symbol counting, decision, and output registers stay in the top.

## Test plan
Bench parameters: SPS=64, M=4, ZC_BASE=8, ZC_STEP_LOG2=2, HYST=6000.

1. ±10000 square wave, starting +, toggling every 8 samples → 7 crossings, `zc_count`=7, `sym_out`=0, `sym_valid` one cycle after sample 63.
2. Toggle every 4 samples → 15 crossings, `sym_out`=2. Toggle every sample → 63 crossings, clamped `sym_out`=3.
3. Test 2's every-4-sample square wave (±10000) with added uniform noise in ±4000 → `zc_count`=15 unchanged; noise-only input of ±4000 → 0 crossings, `sym_out`=0.
4. `sym_start` pulsed at sample 30 → no `sym_valid` at sample 63 of the old alignment; next `sym_valid` 64 samples after the `sym_start` sample.
5. `rst` asserted at sample 40 mid-symbol → all outputs 0, FSM UNK; first post-reset symbol emitted after 64 new samples.
6. `sample_valid` held low for 10 cycles mid-symbol → identical `zc_count`/`sym_out` to the gap-free run, with `sym_valid` delayed by exactly 10 cycles.
